clock_alarm: RTL and testbench
==============================

Name: clock_alarm

Overview:
- Alarm stage directly downstream of the `clock` time counter. Consumes `count_sec`/`count_min`/`count_hrs`.
- Holds a programmable alarm time and raises `ring` when the running time reaches it.
- Supports stop, snooze (re-ring after `SNOOZE_MIN` minutes) and an automatic ring timeout of `RING_SECS` seconds.
- Output feeds the buzzer/LED driver.

Parameters:
- RING_SECS, 60, number of second ticks `ring` stays high before auto-stop (1..63)
- SNOOZE_MIN, 5, snooze delay in minutes (1..59)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset)
- count_sec  input  6  current seconds from clock, 0..59
- count_min  input  6  current minutes from clock, 0..59
- count_hrs  input  6  current hours from clock, 0..23
- alarm_on  input  1  alarm enable level
- set_en  input  1  one-cycle strobe: load set_hrs/set_min as alarm time
- set_hrs  input  6  alarm hours to load
- set_min  input  6  alarm minutes to load
- snooze  input  1  one-cycle snooze request
- stop  input  1  one-cycle stop request
- alarm_hrs  output  6  stored alarm hours
- alarm_min  output  6  stored alarm minutes
- ring  output  1  alarm sounding
- snoozing  output  1  snooze pending
- set_err  output  1  one-cycle pulse: rejected set request

Behaviour:
- Reset (`reset`=0, async): state=IDLE; alarm_hrs=0, alarm_min=0, ring=0, snoozing=0, set_err=0, prev_sec=0, ring_cnt=0, snooze target=0:00. All outputs registered.
- Tick detect: prev_sec <= count_sec every cycle. tick = (count_sec != prev_sec).
- Match(h,m) = tick & count_sec==0 & count_hrs==h & count_min==m. Fires at most once per minute.
- Set:
  - set_en with set_hrs<=23 and set_min<=59 loads alarm_hrs/alarm_min next edge.
  - Otherwise no load; set_err=1 for exactly one cycle.
  - A valid set in RINGING or SNOOZING also forces IDLE, with ring=0 and snoozing=0.
- States: IDLE, RINGING, SNOOZING. ring=1 only in RINGING; snoozing=1 only in SNOOZING.
- IDLE -> RINGING: alarm_on & Match(alarm_hrs, alarm_min). ring rises on the edge after the cycle count_sec first reads 0 (1-cycle latency). ring_cnt cleared.
- RINGING:
  - Priority, highest first: valid set > alarm_on=0 > stop > snooze > timeout.
  - alarm_on=0 or stop: -> IDLE.
  - snooze: -> SNOOZING. Snooze target = current time + SNOOZE_MIN minutes, with minutes wrapping mod 60 and carrying into hours, and hours wrapping mod 24 (23:58 + 5 = 00:03).
  - On each tick ring_cnt++. Tick while ring_cnt==RING_SECS-1: -> IDLE. The ring pulse therefore spans exactly RING_SECS ticks.
- SNOOZING:
  - Match(target) -> RINGING, ring_cnt cleared.
  - stop or alarm_on=0 -> IDLE.
  - snooze ignored.
  - The original alarm time also re-triggers RINGING if it matches while snoozing.
- Inputs with stop=snooze=1 in the same cycle: stop wins.
- set_en with a Match in the same cycle: the set is applied, comparison uses the old alarm, and the state is forced to IDLE (the set wins).
- alarm_on=0 in IDLE: Match ignored. Stored alarm time is retained.
- Reset mid-ring: ring drops immediately (async). Alarm time returns to 0:00.

Test Plan:
- Reset, set 1:00, alarm_on=1, clock free-runs (1 s/cycle) -> ring rises one cycle after count_hrs=1,min=0,sec=0 and stays high exactly 60 ticks; alarm_hrs=1, alarm_min=0.
- Set 0:02, stop pulsed 10 ticks into ring -> ring=0 next edge, state IDLE, no re-ring at 0:02:59.
- Set 0:02, snooze at 0:02:05 -> snoozing=1, ring=0; ring reasserts at 0:07:00.
- Set 23:58, snooze at 23:58:10 -> target 00:03, ring at 0:03:00 after hour wrap.
- set_hrs=24 or set_min=60 -> set_err one cycle; alarm_hrs/alarm_min unchanged.
- Assert reset (low) while ring=1 -> ring=0 immediately; alarm 0:00. stop+snooze same cycle -> IDLE, snoozing=0.

Source files
------------

// File: rtl/clock_alarm.sv
// Alarm stage fed by the time-of-day counter: stores an alarm time, rings on match,
// supports stop, snooze and an automatic ring timeout.
module clock_alarm #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] count_sec,
    input  logic [5:0] count_min,
    input  logic [5:0] count_hrs,
    input  logic       alarm_on,
    input  logic       set_en,
    input  logic [5:0] set_hrs,
    input  logic [5:0] set_min,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] alarm_hrs,
    output logic [5:0] alarm_min,
    output logic       ring,
    output logic       snoozing,
    output logic       set_err
);

    localparam logic [5:0] LP_RING_LAST = 6'(RING_SECS - 1);
    localparam logic [6:0] LP_SNOOZE    = 7'(SNOOZE_MIN);

    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZING} state_t;

    state_t     r_state, w_state_next;
    logic [5:0] r_prev_sec;
    logic [5:0] r_ring_cnt, w_ring_cnt_next;
    logic [5:0] r_snz_hrs, r_snz_min, w_snz_hrs_next, w_snz_min_next;
    logic [5:0] r_alarm_hrs, r_alarm_min;
    logic       r_ring, r_snoozing, r_set_err;
    logic       w_ring_next, w_snoozing_next, w_set_err_next;

    logic       w_tick, w_minute_top, w_match_alarm, w_match_snz, w_set_valid;
    logic [6:0] w_min_sum, w_min_wrapped;
    logic       w_min_wrap;
    logic [5:0] w_tgt_min, w_tgt_hrs;

    assign w_tick        = (count_sec != r_prev_sec);
    assign w_minute_top  = w_tick && (count_sec == 6'd0);
    assign w_match_alarm = w_minute_top && (count_hrs == r_alarm_hrs) && (count_min == r_alarm_min);
    assign w_match_snz   = w_minute_top && (count_hrs == r_snz_hrs) && (count_min == r_snz_min);
    assign w_set_valid   = set_en && (set_hrs <= 6'd23) && (set_min <= 6'd59);

    // Snooze target: minutes wrap mod 60 with carry into hours, hours wrap mod 24
    assign w_min_sum     = {1'b0, count_min} + LP_SNOOZE;
    assign w_min_wrap    = (w_min_sum >= 7'd60);
    assign w_min_wrapped = w_min_wrap ? (w_min_sum - 7'd60) : w_min_sum;
    assign w_tgt_min     = w_min_wrapped[5:0];
    assign w_tgt_hrs     = !w_min_wrap ? count_hrs :
                           (count_hrs == 6'd23) ? 6'd0 : (count_hrs + 6'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_prev_sec  <= 6'd0;
            r_ring_cnt  <= 6'd0;
            r_snz_hrs   <= 6'd0;
            r_snz_min   <= 6'd0;
            r_alarm_hrs <= 6'd0;
            r_alarm_min <= 6'd0;
            r_ring      <= 1'b0;
            r_snoozing  <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_prev_sec <= count_sec;
            r_ring_cnt <= w_ring_cnt_next;
            r_snz_hrs  <= w_snz_hrs_next;
            r_snz_min  <= w_snz_min_next;
            r_ring     <= w_ring_next;
            r_snoozing <= w_snoozing_next;
            r_set_err  <= w_set_err_next;
            if (w_set_valid) begin
                r_alarm_hrs <= set_hrs;
                r_alarm_min <= set_min;
            end
        end
    end

    // A valid set always wins and parks the FSM in IDLE
    always_comb begin
        w_state_next    = r_state;
        w_ring_cnt_next = r_ring_cnt;
        w_snz_hrs_next  = r_snz_hrs;
        w_snz_min_next  = r_snz_min;
        case (r_state)
            S_IDLE: begin
                if (!w_set_valid && alarm_on && w_match_alarm) begin
                    w_state_next    = S_RINGING;
                    w_ring_cnt_next = 6'd0;
                end
            end
            S_RINGING: begin
                if (w_set_valid || !alarm_on || stop) begin
                    w_state_next = S_IDLE;
                end else if (snooze) begin
                    w_state_next   = S_SNOOZING;
                    w_snz_hrs_next = w_tgt_hrs;
                    w_snz_min_next = w_tgt_min;
                end else if (w_tick) begin
                    if (r_ring_cnt == LP_RING_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_ring_cnt_next = r_ring_cnt + 6'd1;
                    end
                end
            end
            S_SNOOZING: begin
                if (w_set_valid || !alarm_on || stop) begin
                    w_state_next = S_IDLE;
                end else if (w_match_snz || w_match_alarm) begin
                    w_state_next    = S_RINGING;
                    w_ring_cnt_next = 6'd0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ring_next     = (w_state_next == S_RINGING);
        w_snoozing_next = (w_state_next == S_SNOOZING);
        w_set_err_next  = set_en && !w_set_valid;
    end

    assign alarm_hrs = r_alarm_hrs;
    assign alarm_min = r_alarm_min;
    assign ring      = r_ring;
    assign snoozing  = r_snoozing;
    assign set_err   = r_set_err;

endmodule

// File: tb/tb_clock_alarm.sv
// Directed bench for clock_alarm: the bench plays the time counter, one second per clock.
module tb_clock_alarm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] count_sec, count_min, count_hrs;
    logic       alarm_on, set_en, snooze, stop;
    logic [5:0] set_hrs, set_min;
    logic [5:0] alarm_hrs, alarm_min;
    logic       ring, snoozing, set_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int t_hrs, t_min, t_sec;
    int n_high, n_bad;

    clock_alarm #(.RING_SECS(60), .SNOOZE_MIN(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .count_sec (count_sec),
        .count_min (count_min),
        .count_hrs (count_hrs),
        .alarm_on  (alarm_on),
        .set_en    (set_en),
        .set_hrs   (set_hrs),
        .set_min   (set_min),
        .snooze    (snooze),
        .stop      (stop),
        .alarm_hrs (alarm_hrs),
        .alarm_min (alarm_min),
        .ring      (ring),
        .snoozing  (snoozing),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-16s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive_time();
        count_sec = 6'(t_sec);
        count_min = 6'(t_min);
        count_hrs = 6'(t_hrs);
    endtask

    // Jump the time counter, then let one edge register it (never lands on sec 0)
    task automatic set_time(input int h, input int m, input int s);
        t_hrs = h; t_min = m; t_sec = s;
        drive_time();
        @(posedge clk); #1;
    endtask

    task automatic advance();
        t_sec++;
        if (t_sec == 60) begin
            t_sec = 0;
            t_min++;
            if (t_min == 60) begin
                t_min = 0;
                t_hrs = (t_hrs + 1) % 24;
            end
        end
        drive_time();
        @(posedge clk); #1;
    endtask

    task automatic load_alarm(input int h, input int m);
        set_hrs = 6'(h); set_min = 6'(m); set_en = 1'b1;
        advance();
        set_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; alarm_on = 1'b0; set_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        set_hrs = 6'd0; set_min = 6'd0;
        t_hrs = 0; t_min = 0; t_sec = 0;
        drive_time();
        #2 reset = 1'b0;
        #1;
        check("rst_ring", ring, 0);
        check("rst_snoozing", snoozing, 0);
        check("rst_set_err", set_err, 0);
        check("rst_alarm_hrs", alarm_hrs, 0);
        check("rst_alarm_min", alarm_min, 0);
        @(posedge clk); #1 reset = 1'b1;

        // alarm_on low: 0:00 match ignored; high: rings
        set_time(23, 59, 59); advance();
        check("off_no_ring", ring, 0);
        alarm_on = 1'b1;
        set_time(23, 59, 59); advance();
        check("midnight_ring", ring, 1);
        stop = 1'b1; advance(); stop = 1'b0;
        check("midnight_stop", ring, 0);

        // 1:00 alarm rings for exactly 60 ticks
        load_alarm(1, 0);
        check("t1_alarm_hrs", alarm_hrs, 1);
        check("t1_alarm_min", alarm_min, 0);
        set_time(0, 59, 59); advance();
        check("t1_rise", ring, 1);
        n_high = 1;
        for (int i = 0; i < 100 && ring === 1'b1; i++) begin
            advance();
            if (ring === 1'b1) n_high++;
        end
        check("t1_ring_len", n_high, 60);
        check("t1_autostop", ring, 0);
        check("t1_stop_time", t_min * 60 + t_sec, 60);

        // stop 10 ticks into ring, no re-ring in the same minute
        load_alarm(0, 2);
        set_time(0, 1, 59); advance();
        check("c_rise", ring, 1);
        repeat (10) advance();
        check("c_still_ring", ring, 1);
        stop = 1'b1; advance(); stop = 1'b0;
        check("c_stop_ring", ring, 0);
        check("c_stop_snz", snoozing, 0);
        n_bad = 0;
        repeat (55) begin advance(); if (ring !== 1'b0) n_bad++; end
        check("c_no_rering", n_bad, 0);

        // snooze at 0:02:05 -> re-ring at 0:07:00
        set_time(0, 1, 59); advance();
        check("d_rise", ring, 1);
        repeat (4) advance();
        snooze = 1'b1; advance(); snooze = 1'b0;
        check("d_snz_ring", ring, 0);
        check("d_snz_flag", snoozing, 1);
        n_bad = 0;
        repeat (294) begin advance(); if (ring !== 1'b0 || snoozing !== 1'b1) n_bad++; end
        check("d_wait_quiet", n_bad, 0);
        advance();
        check("d_rering", ring, 1);
        check("d_rering_snz", snoozing, 0);
        stop = 1'b1; advance(); stop = 1'b0;

        // 23:58 + 5 min wraps to 00:03
        load_alarm(23, 58);
        set_time(23, 57, 59); advance();
        check("e_rise", ring, 1);
        repeat (9) advance();
        snooze = 1'b1; advance(); snooze = 1'b0;
        check("e_snz_flag", snoozing, 1);
        n_bad = 0;
        repeat (289) begin advance(); if (ring !== 1'b0) n_bad++; end
        check("e_wait_quiet", n_bad, 0);
        check("e_wait_time", t_hrs * 3600 + t_min * 60 + t_sec, 179);
        advance();
        check("e_wrap_ring", ring, 1);
        stop = 1'b1; snooze = 1'b1; advance(); stop = 1'b0; snooze = 1'b0;
        check("stop_wins_ring", ring, 0);
        check("stop_wins_snz", snoozing, 0);

        // invalid sets pulse set_err for one cycle, alarm unchanged
        load_alarm(24, 10);
        check("f_err_hrs", set_err, 1);
        check("f_keep_hrs", alarm_hrs, 23);
        check("f_keep_min", alarm_min, 58);
        advance();
        check("f_err_clear", set_err, 0);
        load_alarm(5, 60);
        check("f_err_min", set_err, 1);
        check("f_keep_hrs2", alarm_hrs, 23);
        advance();
        check("f_err_clear2", set_err, 0);

        // async reset while ringing
        load_alarm(0, 2);
        set_time(0, 1, 59); advance();
        check("g_rise", ring, 1);
        advance();
        #2 reset = 1'b0;
        #1;
        check("g_rst_ring", ring, 0);
        check("g_rst_alarm_hrs", alarm_hrs, 0);
        check("g_rst_alarm_min", alarm_min, 2 - 2);
        @(posedge clk); #1 reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
